uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, number of TICK pulses per bit period (even, >=8).
REQ-003 CLK  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 TICK  input  1  oversample strobe from baudrate, one CLK wide, OVERSAMPLE per bit.
REQ-006 RXD  input  1  serial line, asynchronous to CLK, idle high.
REQ-007 full  input  1  receive FIFO full flag.
REQ-008 wr_en  output  1  one-CLK write strobe into receive FIFO.
REQ-009 wr_data  output  DATA_WIDTH  received word, LSB first on line.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 frame_err  output  1  one-CLK pulse on bad stop bit.
REQ-012 overrun_err  output  1  one-CLK pulse when a good word is dropped because full=1.

Function
REQ-013 RXD SHALL pass a 2-flop synchronizer; all decisions use the synchronized value.
REQ-014 States SHALL be IDLE, START, DATA, STOP, WAIT_IDLE (plus PARITY per REQ-026).
REQ-015 IDLE -> START on synchronized RXD high-to-low; tick counter cleared.
REQ-016 Each bit value SHALL be the 2-of-3 majority of samples at TICK counts OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1 within the bit.
REQ-017 START: voted 1 -> false start, return to IDLE, no outputs; voted 0 -> DATA at end of bit period.
REQ-018 DATA: DATA_WIDTH bits, shifted LSB first; bit counter wraps to 0 on exit to STOP.
REQ-019 STOP is decided at the third vote sample (mid-bit), not end of bit, allowing back-to-back frames.
REQ-020 STOP voted 1 and full=0: wr_en=1 for exactly the CLK after the deciding TICK, wr_data valid that cycle and held until the next write; then IDLE.
REQ-021 STOP voted 1 and full=1: no wr_en, overrun_err pulse, wr_data unchanged; then IDLE.
REQ-022 STOP voted 0: frame_err pulse, no write; go to WAIT_IDLE, leave only when synchronized RXD=1 (break handling).
REQ-023 Counters advance only on CLK cycles with TICK=1; no TICK -> state frozen.
REQ-024 full is sampled in the same cycle as the STOP decision only.

Reset
REQ-025 RST=1 at any time, including mid-frame, SHALL immediately force IDLE, counters 0, shift register 0, synchronizer flops 1, wr_data 0, wr_en/busy/frame_err/overrun_err/parity_err 0; a partial frame is discarded and reception resumes on the next falling edge after release.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: PARITY state between DATA and STOP, even parity over data bits, output parity_err (1 bit) pulses one CLK on mismatch, word not written, state goes to IDLE after the stop bit; frame_err takes precedence if both.
REQ-027 Macro undefined: no PARITY state, no parity_err port, frame = start + DATA_WIDTH + stop.

Structure
REQ-028 Package uart_pkg SHALL hold the state enumeration, OVERSAMPLE default and DATA_WIDTH default, shared with the transmitter.
REQ-029 One sub-module sync_2ff (2-flop synchronizer, reset to 1) SHALL be instantiated for RXD.

Verification
REQ-030 Frame 0x55, full=0, OVERSAMPLE=16 -> one wr_en, wr_data=0x55, no error pulses.
REQ-031 Back-to-back 0xA3 then 0x0F with no idle gap -> two wr_en pulses, data 0xA3 then 0x0F.
REQ-032 RXD low for 4 TICKs then high -> no wr_en, no errors, busy returns low, state IDLE.
REQ-033 Frame 0x3C with stop bit 0, then RXD low 30 bit periods -> one frame_err, no wr_en, busy high until RXD rises.
REQ-034 Frame 0x81 with full=1 -> overrun_err once, no wr_en, wr_data keeps previous value.
REQ-035 RST pulse during data bit 4 of 0xFF, then valid 0x12 -> only 0x12 written; with UART_RX_PARITY_EN, 0x07 with parity bit 0 -> parity_err once, no wr_en.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry and the bit-vote helper.
// Compile with +define+UART_RX_PARITY_EN to add the PARITY state.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int OVERSAMPLE_DEF = 16;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_IDLE
  } state_t;
`endif

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: oversample strobe, serial line, FIFO write port and status pulses.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if import uart_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                  TICK;
  logic                  RXD;
  logic                  full;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  busy;
  logic                  frame_err;
  logic                  overrun_err;
`ifdef UART_RX_PARITY_EN
  logic                  parity_err;
`endif

  modport slave (
    input  TICK, RXD, full,
    output wr_en, wr_data, busy, frame_err, overrun_err
`ifdef UART_RX_PARITY_EN
    , output parity_err
`endif
  );

  modport master (
    output TICK, RXD, full,
    input  wr_en, wr_data, busy, frame_err, overrun_err
`ifdef UART_RX_PARITY_EN
    , input parity_err
`endif
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous level; powers up and resets to 1 (line idle).
// Latency: two clocks.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-of-3 mid-bit vote, stop decided mid-bit, one-CLK write/error pulses.
// No backpressure: a good word arriving while full=1 is dropped with overrun_err. Macro: UART_RX_PARITY_EN.
module uart_rx import uart_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input logic      CLK,
  input logic      RST,
  uart_rx_if.slave bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] SMP_A    = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] SMP_B    = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] SMP_C    = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [1:0]            smp_q, smp_d;
  logic                  wr_en_q, wr_en_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  rxd_s, rxd_prev_q;
  logic                  vote, at_vote, at_end;
`ifdef UART_RX_PARITY_EN
  logic                  par_bit_q, par_bit_d;
  logic                  parity_err_q, parity_err_d;
`endif

  sync_2ff u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (bus.RXD),
    .q   (rxd_s)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      wr_data_q    <= '0;
      smp_q        <= 2'b11;
      wr_en_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      rxd_prev_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      wr_data_q    <= wr_data_d;
      smp_q        <= smp_d;
      wr_en_q      <= wr_en_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      rxd_prev_q   <= rxd_s;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    // The third vote sample is the live synchronized value, so each bit resolves on that TICK.
    vote        = maj3(smp_q[1], smp_q[0], rxd_s);
    at_vote     = bus.TICK && (tick_cnt_q == SMP_C);
    at_end      = bus.TICK && (tick_cnt_q == BIT_END);
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    wr_data_d   = wr_data_q;
    smp_d       = smp_q;
    wr_en_d     = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif
    if (bus.TICK) begin
      tick_cnt_d = at_end ? '0 : tick_cnt_q + 1'b1;
      if (tick_cnt_q == SMP_A) smp_d[1] = rxd_s;
      if (tick_cnt_q == SMP_B) smp_d[0] = rxd_s;
    end

    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        if (rxd_prev_q && !rxd_s) state_d = START;
      end
      START: begin
        if (at_vote && vote) state_d = IDLE;
        else if (at_end)     state_d = DATA;
      end
      DATA: begin
        if (at_vote) shreg_d = {vote, shreg_q[DATA_WIDTH-1:1]};
        if (at_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (at_vote) par_bit_d = vote;
        if (at_end)  state_d = STOP;
      end
`endif
      STOP: begin
        if (at_vote) begin
          if (!vote) begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end else begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bit_q != ^shreg_q) parity_err_d = 1'b1;
            else
`endif
            if (bus.full) begin
              overrun_d = 1'b1;
            end else begin
              wr_en_d   = 1'b1;
              wr_data_d = shreg_q;
            end
          end
        end
      end
      WAIT_IDLE: begin
        tick_cnt_d = '0;
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.frame_err   = frame_err_q;
  assign bus.overrun_err = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err  = parity_err_q;
`endif

endmodule
